// File: rtl/ml_pkg.sv
// Shared Morphle definitions for the clocked yellow-cell compare row.
//   - Two-bit Morphle value codes (empty, zero, one, illegal).
//   - Per-cell FSM state encoding.
//   - Small value-classification helpers used by the cell FSM.
package ml_pkg;

  localparam logic [1:0] Vempty   = 2'b00;
  localparam logic [1:0] V0       = 2'b01;
  localparam logic [1:0] V1       = 2'b10;
  localparam logic [1:0] Villegal = 2'b11;

  typedef enum logic [1:0] {
    WAIT_EMPTY = 2'd0,
    IDLE       = 2'd1,
    RESULT     = 2'd2
  } cell_state_t;

  // Any code other than the reserved 2'b11 is a legal wire value.
  function automatic logic is_valid(input logic [1:0] v);
    return v != Villegal;
  endfunction

  // A real data token: legal and not empty.
  function automatic logic is_token(input logic [1:0] v);
    return (v == V0) || (v == V1);
  endfunction

endpackage

// File: rtl/ycfsm_sync_cell.sv
// One compare cell of the yellow-cell row.
//   Latches a token on `in` and on `match`. Once both are held, it
//   registers the compare result on `out`. It then waits for both inputs to
//   return to empty before it accepts the next token.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   in     2-bit Morphle data value
//   match  2-bit Morphle match value
//   out    registered compare result (Vempty while no result is held)
//   err    sticky protocol-error flag
import ml_pkg::*;

module ycfsm_sync_cell #(
  parameter int INVERT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] in,
  input  logic [1:0] match,
  output logic [1:0] out,
  output logic       err
);

  cell_state_t state;
  logic [1:0]  lin;
  logic [1:0]  lmatch;
  logic        in_gone;     // `in` has returned to empty during RESULT
  logic        match_gone;  // `match` has returned to empty during RESULT

  logic [1:0]  nxt_lin;
  logic [1:0]  nxt_lmatch;
  logic        in_done;
  logic        match_done;

  function automatic logic [1:0] compare(input logic [1:0] a, input logic [1:0] b);
    logic eq;
    eq = (a == b);
    return (eq ^ (INVERT != 0)) ? V1 : V0;
  endfunction

  // In IDLE, an empty latch captures the first token seen. A full latch keeps
  // its value. Both latches can fill on the same edge.
  always_comb begin
    nxt_lin    = lin;
    nxt_lmatch = lmatch;
    if (lin == Vempty && is_token(in))
      nxt_lin = in;
    if (lmatch == Vempty && is_token(match))
      nxt_lmatch = match;
  end

  // Once an input has emptied, it counts as empty even if it reasserts early.
  assign in_done    = in_gone    || (in    == Vempty);
  assign match_done = match_gone || (match == Vempty);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= WAIT_EMPTY;
      out        <= Vempty;
      err        <= 1'b0;
      lin        <= Vempty;
      lmatch     <= Vempty;
      in_gone    <= 1'b0;
      match_gone <= 1'b0;
    end else begin
      if (!is_valid(in) || !is_valid(match))
        err <= 1'b1;

      case (state)
        // Drop any token that was held across reset.
        WAIT_EMPTY: begin
          out <= Vempty;
          if (in == Vempty && match == Vempty)
            state <= IDLE;
        end

        IDLE: begin
          lin    <= nxt_lin;
          lmatch <= nxt_lmatch;
          if (is_token(nxt_lin) && is_token(nxt_lmatch)) begin
            state <= RESULT;
            out   <= compare(nxt_lin, nxt_lmatch);
          end
        end

        RESULT: begin
          if (!in_gone) begin
            if (in == Vempty)
              in_gone <= 1'b1;
            else if (in != lin)
              err <= 1'b1;
          end else if (in != Vempty) begin
            err <= 1'b1;
          end

          if (!match_gone) begin
            if (match == Vempty)
              match_gone <= 1'b1;
            else if (match != lmatch)
              err <= 1'b1;
          end else if (match != Vempty) begin
            err <= 1'b1;
          end

          if (in_done && match_done) begin
            state      <= IDLE;
            out        <= Vempty;
            lin        <= Vempty;
            lmatch     <= Vempty;
            in_gone    <= 1'b0;
            match_gone <= 1'b0;
          end
        end

        default: state <= WAIT_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/ycfsm_sync_row.sv
// Row of N_CELLS independent yellow-cell compare cells.
//   Adds a registered row-wide AND result and a counter of completed row
//   tokens.
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-high
//   in       per-cell data values, cell i at [2i+1:2i]
//   match    per-cell match values, same packing
//   out      per-cell registered results, same packing
//   row_out  registered row result (V1 all-ones, V0 any zero, else Vempty)
//   err      sticky per-cell protocol-error flags
//   tok_cnt  completed row tokens, wraps modulo 2^CNT_W
import ml_pkg::*;

module ycfsm_sync_row #(
  parameter int N_CELLS = 8,
  parameter int INVERT  = 0,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2*N_CELLS-1:0] in,
  input  logic [2*N_CELLS-1:0] match,
  output logic [2*N_CELLS-1:0] out,
  output logic [1:0]           row_out,
  output logic [N_CELLS-1:0]   err,
  output logic [CNT_W-1:0]     tok_cnt
);

  logic [1:0] row_nxt;

  for (genvar i = 0; i < N_CELLS; i++) begin : g_cell
    ycfsm_sync_cell #(
      .INVERT (INVERT)
    ) u_cell (
      .clk   (clk),
      .reset (reset),
      .in    (in[2*i+1:2*i]),
      .match (match[2*i+1:2*i]),
      .out   (out[2*i+1:2*i]),
      .err   (err[i])
    );
  end

  // Row reduction over the registered cell outputs. Cells only ever present
  // Vempty, V0 or V1.
  always_comb begin
    logic all_v1;
    logic all_tok;
    all_v1  = 1'b1;
    all_tok = 1'b1;
    for (int i = 0; i < N_CELLS; i++) begin
      if (out[2*i +: 2] != V1)
        all_v1 = 1'b0;
      if (!is_token(out[2*i +: 2]))
        all_tok = 1'b0;
    end
    row_nxt = Vempty;
    if (all_v1)
      row_nxt = V1;
    else if (all_tok)
      row_nxt = V0;
  end

  // Row result stage: one edge behind the cell outputs. The counter fires on
  // the empty-to-token transition of row_out.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_out <= Vempty;
      tok_cnt <= '0;
    end else begin
      row_out <= row_nxt;
      if (row_out == Vempty && row_nxt != Vempty)
        tok_cnt <= tok_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ycfsm_sync_row.sv
// Directed, table-driven bench for ycfsm_sync_row. It uses three instances:
//   u1  : N_CELLS=1, CNT_W=2  (single-cell latency and counter wrap)
//   u4  : N_CELLS=4           (vector table, error flags, reset mid-token)
//   u4i : N_CELLS=4, INVERT=1 (inverted compare)
module tb_ycfsm_sync_row;

  logic clk;
  logic rst1, rst4, rst4i;

  logic [1:0]  in1, match1, out1, row1, cnt1;
  logic [0:0]  err1;
  logic [7:0]  in4, match4, out4;
  logic [1:0]  row4;
  logic [3:0]  err4;
  logic [15:0] cnt4;
  logic [7:0]  in4i, match4i, out4i;
  logic [1:0]  row4i;
  logic [3:0]  err4i;
  logic [15:0] cnt4i;

  int n_cmp = 0;
  int n_bad = 0;

  ycfsm_sync_row #(.N_CELLS(1), .INVERT(0), .CNT_W(2)) u1 (
    .clk(clk), .reset(rst1), .in(in1), .match(match1),
    .out(out1), .row_out(row1), .err(err1), .tok_cnt(cnt1));

  ycfsm_sync_row #(.N_CELLS(4), .INVERT(0), .CNT_W(16)) u4 (
    .clk(clk), .reset(rst4), .in(in4), .match(match4),
    .out(out4), .row_out(row4), .err(err4), .tok_cnt(cnt4));

  ycfsm_sync_row #(.N_CELLS(4), .INVERT(1), .CNT_W(16)) u4i (
    .clk(clk), .reset(rst4i), .in(in4i), .match(match4i),
    .out(out4i), .row_out(row4i), .err(err4i), .tok_cnt(cnt4i));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  in;
    logic [7:0]  match;
    logic [7:0]  o;
    logic [1:0]  row;
    logic [3:0]  err;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[17];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [1:0] cnt_exp[4];

    // Cell i at [2i+1:2i]; 55 = all V0, AA = all V1, 59 = cell1 V1 rest V0.
    tbl[0]  = '{8'h00, 8'h00, 8'h00, 2'b00, 4'h0, 16'd0};
    tbl[1]  = '{8'h55, 8'h59, 8'hA6, 2'b00, 4'h0, 16'd0};
    tbl[2]  = '{8'h55, 8'h59, 8'hA6, 2'b01, 4'h0, 16'd1};
    tbl[3]  = '{8'h00, 8'h59, 8'hA6, 2'b01, 4'h0, 16'd1};
    tbl[4]  = '{8'h00, 8'h00, 8'h00, 2'b01, 4'h0, 16'd1};
    tbl[5]  = '{8'h00, 8'h00, 8'h00, 2'b00, 4'h0, 16'd1};
    tbl[6]  = '{8'hAA, 8'h00, 8'h00, 2'b00, 4'h0, 16'd1};
    tbl[7]  = '{8'hAA, 8'hAA, 8'hAA, 2'b00, 4'h0, 16'd1};
    tbl[8]  = '{8'hAA, 8'hAA, 8'hAA, 2'b10, 4'h0, 16'd2};
    tbl[9]  = '{8'h00, 8'h00, 8'h00, 2'b10, 4'h0, 16'd2};
    tbl[10] = '{8'h00, 8'h00, 8'h00, 2'b00, 4'h0, 16'd2};
    tbl[11] = '{8'hAA, 8'h0A, 8'h0A, 2'b00, 4'h0, 16'd2};
    tbl[12] = '{8'hAA, 8'h0A, 8'h0A, 2'b00, 4'h0, 16'd2};
    tbl[13] = '{8'hAA, 8'hAA, 8'hAA, 2'b00, 4'h0, 16'd2};
    tbl[14] = '{8'hAA, 8'hAA, 8'hAA, 2'b10, 4'h0, 16'd3};
    tbl[15] = '{8'h00, 8'h00, 8'h00, 2'b10, 4'h0, 16'd3};
    tbl[16] = '{8'h00, 8'h00, 8'h00, 2'b00, 4'h0, 16'd3};

    cnt_exp[0] = 2'd2;
    cnt_exp[1] = 2'd3;
    cnt_exp[2] = 2'd0;
    cnt_exp[3] = 2'd1;

    // Reset state
    rst1 = 1'b1; rst4 = 1'b1; rst4i = 1'b1;
    in1 = '0; match1 = '0; in4 = '0; match4 = '0; in4i = '0; match4i = '0;
    step();
    step();
    chk("reset out1",  32'(out1), 32'h0);
    chk("reset row1",  32'(row1), 32'h0);
    chk("reset cnt1",  32'(cnt1), 32'h0);
    chk("reset out4",  32'(out4), 32'h0);
    chk("reset row4",  32'(row4), 32'h0);
    chk("reset err4",  32'(err4), 32'h0);
    chk("reset cnt4",  32'(cnt4), 32'h0);
    chk("reset out4i", 32'(out4i), 32'h0);
    rst1 = 1'b0; rst4 = 1'b0; rst4i = 1'b0;

    // Single cell: in first, match three cycles later
    step();
    in1 = 2'b10;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("u1 wait out %0d", k), 32'(out1), 32'h0);
    end
    match1 = 2'b10;
    step();
    chk("u1 out after match", 32'(out1), 32'h2);
    chk("u1 row lag",         32'(row1), 32'h0);
    step();
    chk("u1 row V1", 32'(row1), 32'h2);
    chk("u1 cnt 1",  32'(cnt1), 32'h1);
    in1 = 2'b00; match1 = 2'b00;
    step();
    chk("u1 out empty", 32'(out1), 32'h0);
    step();
    chk("u1 row empty", 32'(row1), 32'h0);

    // Counter wrap with CNT_W=2
    for (int k = 0; k < 4; k++) begin
      in1 = 2'b10; match1 = 2'b01;
      step();
      chk($sformatf("u1 tok%0d out", k), 32'(out1), 32'h1);
      step();
      chk($sformatf("u1 tok%0d cnt", k), 32'(cnt1), 32'(cnt_exp[k]));
      in1 = 2'b00; match1 = 2'b00;
      step();
      step();
    end

    // Inverted compare, mixed match
    in4i = 8'h55; match4i = 8'h59;
    step();
    chk("u4i out", 32'(out4i), 32'h59);
    step();
    chk("u4i row", 32'(row4i), 32'h1);
    chk("u4i cnt", 32'(cnt4i), 32'h1);

    // Vector table on u4
    for (int i = 0; i < 17; i++) begin
      in4 = tbl[i].in;
      match4 = tbl[i].match;
      step();
      chk($sformatf("vec%0d out", i), 32'(out4), 32'(tbl[i].o));
      chk($sformatf("vec%0d row", i), 32'(row4), 32'(tbl[i].row));
      chk($sformatf("vec%0d err", i), 32'(err4), 32'(tbl[i].err));
      chk($sformatf("vec%0d cnt", i), 32'(cnt4), 32'(tbl[i].cnt));
    end

    // Protocol errors during RESULT: cell0 in V1->V0, cell2 match illegal
    in4 = 8'hAA; match4 = 8'hAA;
    step();
    in4 = 8'hA9; match4 = 8'hBA;
    step();
    chk("err set",       32'(err4), 32'h5);
    chk("err out held",  32'(out4), 32'hAA);
    in4 = 8'hAA; match4 = 8'hAA;
    step();
    chk("err sticky",    32'(err4), 32'h5);
    chk("err out held2", 32'(out4), 32'hAA);
    in4 = 8'h00; match4 = 8'h00;
    step();
    step();
    chk("err sticky idle", 32'(err4), 32'h5);
    chk("err out empty",   32'(out4), 32'h0);

    // Reset mid-token, inputs held non-empty
    in4 = 8'hAA; match4 = 8'hAA;
    step();
    chk("pre-reset out", 32'(out4), 32'hAA);
    rst4 = 1'b1;
    step();
    chk("midrst out", 32'(out4), 32'h0);
    chk("midrst row", 32'(row4), 32'h0);
    chk("midrst err", 32'(err4), 32'h0);
    chk("midrst cnt", 32'(cnt4), 32'h0);
    rst4 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("stale token out %0d", k), 32'(out4), 32'h0);
    end
    in4 = 8'h00; match4 = 8'h00;
    step();
    chk("post-rst idle out", 32'(out4), 32'h0);
    in4 = 8'h55; match4 = 8'h55;
    step();
    chk("fresh token out", 32'(out4), 32'hAA);
    step();
    chk("fresh token row", 32'(row4), 32'h2);
    chk("fresh token cnt", 32'(cnt4), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
